// File: rtl/exmem_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: control bit map,
// default-width payload struct and skid-buffer state encoding.
package exmem_pkg;
  localparam int BR  = 0;
  localparam int MRD = 1;
  localparam int M2R = 2;
  localparam int MWR = 3;
  localparam int RWR = 4;
  localparam int AMS = 5;

  localparam int XLEN_DEF   = 64;
  localparam int RD_W_DEF   = 5;
  localparam int CTRL_W_DEF = 6;

  typedef struct packed {
    logic [XLEN_DEF-1:0]   target;
    logic [XLEN_DEF-1:0]   alu;
    logic                  zero;
    logic [XLEN_DEF-1:0]   wdata;
    logic [RD_W_DEF-1:0]   rd;
    logic [CTRL_W_DEF-1:0] ctrl;
  } exmem_payload_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} skid_state_t;
endpackage

// File: rtl/exmem_skid_buf.sv
// Generic two-entry skid buffer; in_ready comes straight from a flop so
// the downstream ready never reaches the upstream ready combinationally.
module exmem_skid_buf
  import exmem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_t state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire, out_fire;

  assign in_fire = in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin state_d = HALF; main_d = in_data; end
      HALF: begin
        if (in_fire && out_fire) main_d = in_data;
        else if (in_fire) begin state_d = FULL; skid_d = in_data; end
        else if (out_fire) state_d = EMPTY;
      end
      FULL: if (out_fire) begin state_d = HALF; main_d = skid_q; end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
endmodule

// File: rtl/exmem_pipe_stage.sv
// EX->MEM stage register with valid/ready flow control, flush, bubble
// gating of the control vector and a saturating back-pressure counter.
module exmem_pipe_stage
  import exmem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 6,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_target,
  input  logic [XLEN-1:0]   in_alu,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_alu,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int PW = 3*XLEN + 1 + RD_W + CTRL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PW-1:0]     in_pl, out_pl;
  logic [CTRL_W-1:0] ctrl_raw;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_pl = {in_target, in_alu, in_zero, in_wdata, in_rd, in_ctrl};

  generate
    if (SKID != 0) begin : g_skid
      exmem_skid_buf #(.W(PW)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_pl)
      );
    end else begin : g_reg
      logic [PW-1:0] data_q, data_d;
      logic          valid_q, valid_d;

      assign in_ready = !valid_q | out_ready;

      always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (in_valid && in_ready) begin
          data_d  = in_pl;
          valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end
        if (flush) begin
          data_d  = '0;
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
        end
      end

      assign out_valid = valid_q;
      assign out_pl    = data_q;
    end
  endgenerate

  assign {out_target, out_alu, out_zero, out_wdata, out_rd, ctrl_raw} = out_pl;
  // Bubbles must never carry memwrite/regwrite into MEM.
  assign out_ctrl = out_valid ? ctrl_raw : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed bench: a SKID=1 stage (dut) and a SKID=0, CNT_W=4 stage (dut0)
// share the same stimulus.
module tb_exmem_pipe_stage;
  import exmem_pkg::*;

  localparam int XLEN = 64, RD_W = 5, CTRL_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush, in_valid, out_ready, in_zero;
  logic [XLEN-1:0]   in_target, in_alu, in_wdata;
  logic [RD_W-1:0]   in_rd;
  logic [CTRL_W-1:0] in_ctrl;

  logic              in_ready, out_valid, out_zero;
  logic [XLEN-1:0]   out_target, out_alu, out_wdata;
  logic [RD_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [15:0]       stall_cnt;

  logic              in_ready0, out_valid0, out_zero0;
  logic [XLEN-1:0]   out_target0, out_alu0, out_wdata0;
  logic [RD_W-1:0]   out_rd0;
  logic [CTRL_W-1:0] out_ctrl0;
  logic [3:0]        stall_cnt0;

  int checks = 0;
  int errors = 0;

  exmem_pipe_stage #(.SKID(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .in_alu(in_alu), .in_zero(in_zero), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_target(out_target), .out_alu(out_alu), .out_zero(out_zero), .out_wdata(out_wdata),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  exmem_pipe_stage #(.SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_target(in_target), .in_alu(in_alu), .in_zero(in_zero), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_target(out_target0), .out_alu(out_alu0), .out_zero(out_zero0), .out_wdata(out_wdata0),
    .out_rd(out_rd0), .out_ctrl(out_ctrl0), .stall_cnt(stall_cnt0)
  );

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_target = '0; in_alu = '0; in_zero = 1'b0; in_wdata = '0; in_rd = '0; in_ctrl = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic send(input logic [XLEN-1:0] alu, input logic [CTRL_W-1:0] ctrl);
    in_valid = 1'b1; in_alu = alu; in_ctrl = ctrl;
    in_target = alu + 64'h1000; in_wdata = ~alu; in_rd = alu[RD_W-1:0]; in_zero = (alu == 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got %0h want 0", out_ctrl); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin errors++;
      $display("FAIL reset_skid0 in_ready=%0b out_valid=%0b want 1/0", in_ready0, out_valid0); end
  endtask

  task automatic test_streaming();
    logic [CTRL_W-1:0] c;
    do_reset();
    out_ready = 1'b1;
    c = '0; c[RWR] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(64'(i), c);
      checks++; if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin errors++;
        $display("FAIL stream_in_ready beat %0d got %0b/%0b want 1/1", i, in_ready, in_ready0); end
      step();
      checks++; if (out_valid !== 1'b1 || out_alu !== 64'(i) || out_ctrl !== c) begin errors++;
        $display("FAIL stream_out beat %0d valid=%0b alu=%0d ctrl=%0h want 1/%0d/%0h", i, out_valid, out_alu, out_ctrl, i, c); end
      checks++; if (out_valid0 !== 1'b1 || out_alu0 !== 64'(i)) begin errors++;
        $display("FAIL stream_out0 beat %0d valid=%0b alu=%0d want 1/%0d", i, out_valid0, out_alu0, i); end
      checks++; if (out_target !== 64'(i) + 64'h1000 || out_rd !== 5'(i)) begin errors++;
        $display("FAIL stream_payload beat %0d target=%0h rd=%0d", i, out_target, out_rd); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_alu !== 64'd8) begin errors++;
      $display("FAIL stream_bubble valid=%0b ctrl=%0h alu=%0d want 0/0/8", out_valid, out_ctrl, out_alu); end
    checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0) begin errors++;
      $display("FAIL stream_bubble0 valid=%0b ctrl=%0h want 0/0", out_valid0, out_ctrl0); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    logic [CTRL_W-1:0] c;
    do_reset();
    c = '0; c[MWR] = 1'b1;
    send(64'hA, c); step();
    checks++; if (out_valid !== 1'b1 || out_alu !== 64'hA || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_after_a valid=%0b alu=%0h in_ready=%0b want 1/a/1", out_valid, out_alu, in_ready); end
    send(64'hB, c); step();
    checks++; if (in_ready !== 1'b0 || out_alu !== 64'hA) begin errors++;
      $display("FAIL bp_full in_ready=%0b alu=%0h want 0/a", in_ready, out_alu); end
    in_valid = 1'b0; step();
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall got %0d want 2", stall_cnt); end
    out_ready = 1'b1; step();
    checks++; if (out_valid !== 1'b1 || out_alu !== 64'hB || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_drain_b valid=%0b alu=%0h in_ready=%0b want 1/b/1", out_valid, out_alu, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin errors++;
      $display("FAIL bp_empty valid=%0b stall=%0d want 0/2", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    logic [CTRL_W-1:0] c;
    do_reset();
    c = '0; c[MWR] = 1'b1;
    send(64'h11, c); step();
    send(64'h22, c); step();
    send(64'h33, c); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || out_alu !== '0) begin errors++;
      $display("FAIL flush_full valid=%0b ctrl=%0h in_ready=%0b alu=%0h want 0/0/1/0", out_valid, out_ctrl, in_ready, out_alu); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_stall got %0d want 2", stall_cnt); end
    out_ready = 1'b1; step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost valid=%0b want 0", out_valid); end
    // Flush while HALF with in_ready high: the offered beat is still dropped.
    out_ready = 1'b0;
    send(64'h44, c); step();
    send(64'h55, c); flush = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_half_ready got %0b want 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    checks++; if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin errors++;
      $display("FAIL flush_half valid=%0b/%0b want 0/0", out_valid, out_valid0); end
  endtask

  task automatic test_reset_mid_stall();
    logic [CTRL_W-1:0] c;
    do_reset();
    c = '0; c[RWR] = 1'b1;
    send(64'h7, c); step();
    send(64'h8, c); step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (stall_cnt !== 16'd5 || in_ready !== 1'b0) begin errors++;
      $display("FAIL mid_stall_pre stall=%0d in_ready=%0b want 5/0", stall_cnt, in_ready); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (stall_cnt !== '0 || out_valid !== 1'b0 || out_ctrl !== '0 || out_alu !== '0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL mid_stall_reset stall=%0d valid=%0b ctrl=%0h alu=%0h in_ready=%0b", stall_cnt, out_valid, out_ctrl, out_alu, in_ready); end
  endtask

  task automatic test_saturation();
    do_reset();
    send(64'h9, '0); step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++; if (stall_cnt0 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d want 15", stall_cnt0); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got %0d want 20", stall_cnt); end
    checks++; if (out_valid0 !== 1'b1 || out_alu0 !== 64'h9) begin errors++;
      $display("FAIL sat_hold0 valid=%0b alu=%0h want 1/9", out_valid0, out_alu0); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
